tl_cntr_multi_dir: RTL
======================

Name: tl_cntr_multi_dir

Overview:
Parametrised successor of the two-road traffic light controller with left turn. Serves N_DIR approaches in round-robin order. Each approach has a straight-green phase and a left-arrow phase, each followed by a timed yellow. Adds minimum green, a maximum-green timeout and multi-cycle yellow. Sits between the synchronous sensor inputs and the lamp drivers.

Parameters:
N_DIR, 2, number of approaches (legal 2..8); phase count is 4*N_DIR.
YELLOW_CYC, 1, cycles each yellow phase lasts (>=1).
MIN_GREEN, 1, minimum cycles in a green or left phase (>=1).
MAX_GREEN, 0, green/left timeout in cycles; 0 = no limit (must be 0 or >= MIN_GREEN).

Ports:
clk  input  1  single clock, all logic on rising edge
reset  input  1  synchronous, active-high reset
T  input  N_DIR  straight-traffic sensor per approach, sampled at clk edge
TL  input  N_DIR  left-turn sensor per approach, sampled at clk edge
L  output  2*N_DIR  lamp code per approach, L[2d+1:2d] = approach d
phase  output  PH_W  current phase index, PH_W = clog2(4*N_DIR)

Behaviour:
- Interface: one clock; reset is synchronous and active-high.
- Lamp codes: 2'b00 GREEN, 2'b01 YELLOW, 2'b10 LEFT, 2'b11 RED.
- Phase p = 4d+k. k=0: approach d GREEN. k=1: d YELLOW. k=2: d LEFT. k=3: d YELLOW. All other approaches RED.
- Moore machine: L and phase are decoded from registered state only. They update on the same edge as the state. No sensor-to-output combinational path.
- Phase counter cnt: cleared on every phase entry, +1 per cycle, saturates at its maximum.
- Go phase (k=0 uses T[d], k=2 uses TL[d]):
  - Exits when cnt >= MIN_GREEN-1 AND (sensor==0 OR (MAX_GREEN!=0 AND cnt==MAX_GREEN-1)).
  - Otherwise it holds.
- Yellow phase: exits when cnt == YELLOW_CYC-1.
- Next phase is p+1. Phase 4*N_DIR-1 wraps to 0.
- Reset (any time, including mid-phase): on the next edge phase=0 and cnt=0. L = approach 0 GREEN, all others RED. Reset overrides every pending transition.
- Defaults (MIN_GREEN=1, YELLOW_CYC=1, MAX_GREEN=0) give the original eight-state behaviour for N_DIR=2:
  - each go phase holds while its sensor is 1;
  - each go phase leaves after one cycle when its sensor is 0;
  - yellow lasts one cycle.
- Sensors that change during yellow have no effect until the next go phase evaluates them.
- Only one approach is ever non-RED. An illegal state encoding recovers to phase 0 on the next edge.

Optional Feature:
Macro TL_SKIP_EMPTY_EN.
- Defined: on yellow exit, search go phases in round-robin order starting after the phase just served. The search excludes that phase and covers the next 2*N_DIR-1 go phases. Jump directly to the first go phase whose sensor is 1. If none is requested, take the normal next phase p+1. Yellow phases are never skipped.
- Undefined: strict sequential p+1 order; no search logic is synthesised.

Test Plan:
1. N_DIR=2 defaults; reset=1 for 1 edge, T=TL=0 -> phase=0, L=4'b1100. Release, T[0]=1 for 5 cycles -> phase stays 0.
2. N_DIR=2 defaults, all sensors 0 after reset -> phase steps 0,1,...,7, one cycle each. Wraps to 0 on cycle 8. L[3:2] shows 00,01,10,01 in phases 4..7.
3. YELLOW_CYC=3, T=TL=0 -> phase 1 held exactly 3 cycles, then phase 2 for 1 cycle.
4. MIN_GREEN=3, MAX_GREEN=5:
   - T[0]=0 -> phase 0 held 3 cycles;
   - T[0]=1 constant -> phase 0 exits after exactly 5 cycles to phase 1.
5. Defaults; assert reset while in phase 5 with cnt mid-count -> next edge phase=0, L=4'b1100. Counter restarts from 0.
6. TL_SKIP_EMPTY_EN, N_DIR=3, only TL[2]=1:
   - phase 0 -> 1 -> 10 (approach 2 LEFT);
   - with all sensors 0 -> normal order 1 -> 2.

Source files
------------

// File: rtl/tl_cntr_multi_dir.sv
// Round-robin traffic light controller for N_DIR approaches, each with a straight-green and a left-arrow phase.
// Latency: lamps and phase index are registered and change on the same edge as the internal phase state.
// Backpressure: none; sensors are sampled every edge, and a go phase holds only while its sensor requests it.
//
// Ports:
//   clk    - single clock, all logic on the rising edge
//   reset  - synchronous active-high reset (phase 0, counter 0, approach 0 GREEN)
//   T      - straight-traffic sensor per approach
//   TL     - left-turn sensor per approach
//   L      - 2-bit lamp code per approach, L[2d+1:2d] = approach d
//            (00 GREEN, 01 YELLOW, 10 LEFT, 11 RED)
//   phase  - current phase index, 4*d + k (k: 0 green, 1 yellow, 2 left, 3 yellow)
//
// Optional build macro TL_SKIP_EMPTY_EN: when a yellow phase ends, jump to the
// next go phase (round-robin, excluding the one just served) whose sensor is
// set, instead of always stepping to phase+1.
module tl_cntr_multi_dir #(
    parameter int N_DIR      = 2,
    parameter int YELLOW_CYC = 1,
    parameter int MIN_GREEN  = 1,
    parameter int MAX_GREEN  = 0,
    localparam int PH_W      = $clog2(4 * N_DIR)
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [N_DIR-1:0]     T,
    input  logic [N_DIR-1:0]     TL,
    output logic [2*N_DIR-1:0]   L,
    output logic [PH_W-1:0]      phase
);

    localparam int N_PH  = 4 * N_DIR;
    localparam int N_GO  = 2 * N_DIR;

    // Counter only needs to reach the largest threshold it is compared to.
    localparam int CNT_T1  = (YELLOW_CYC > MIN_GREEN) ? YELLOW_CYC : MIN_GREEN;
    localparam int CNT_TOP = (CNT_T1 > MAX_GREEN) ? CNT_T1 : MAX_GREEN;
    localparam int CNT_W   = $clog2(CNT_TOP + 1);

    localparam logic [CNT_W-1:0] YEL_LAST = CNT_W'(YELLOW_CYC - 1);
    localparam logic [CNT_W-1:0] MIN_LAST = CNT_W'(MIN_GREEN - 1);
    localparam logic [CNT_W-1:0] MAX_LAST = CNT_W'((MAX_GREEN == 0) ? 0 : MAX_GREEN - 1);
    localparam logic [CNT_W-1:0] CNT_SAT  = '1;

    localparam logic [PH_W-1:0] LAST_PH = PH_W'(N_PH - 1);

    localparam logic [1:0] LAMP_GREEN  = 2'b00;
    localparam logic [1:0] LAMP_YELLOW = 2'b01;
    localparam logic [1:0] LAMP_LEFT   = 2'b10;
    localparam logic [1:0] LAMP_RED    = 2'b11;

    localparam logic [2*N_DIR-1:0] RST_LAMP = {{(2*N_DIR-2){1'b1}}, LAMP_GREEN};

    logic [PH_W-1:0]    phase_q, phase_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [2*N_DIR-1:0] l_q, l_d;

    logic [PH_W-3:0]    dir;
    logic [1:0]         k;
    logic               legal;
    logic               go_sens;
    logic               go_done;
    logic               yel_done;
    logic               adv;
    logic               phase_chg;
    logic [PH_W-1:0]    seq_next;

`ifdef TL_SKIP_EMPTY_EN
    logic [N_GO-1:0]    go_req;
    logic [2*N_GO-1:0]  req_sh;
    logic [N_GO-2:0]    req_rot;
    logic [PH_W-1:0]    srch_base;
    logic [PH_W-1:0]    skip_off;
    logic [PH_W-1:0]    skip_go;
    logic               skip_hit;
    logic [PH_W-1:0]    skip_phase;

    // Go phases are numbered g = phase>>1, so g=2d is approach d straight and
    // g=2d+1 is approach d left. From a yellow phase, the go phase just served
    // is phase>>1; the search window is the 2*N_DIR-1 go phases after it.
    // Doubling the request vector turns the modular window into a plain shift.
    always_comb begin
        go_req = '0;
        for (int d = 0; d < N_DIR; d++) begin
            go_req[2*d]   = T[d];
            go_req[2*d+1] = TL[d];
        end
        srch_base = {1'b0, phase_q[PH_W-1:1]} + 1'b1;
        req_sh    = {go_req, go_req} >> srch_base;
        req_rot   = req_sh[N_GO-2:0];
        skip_hit  = |req_rot;
        // Downward scan so the lowest offset (closest in round-robin) wins.
        skip_off  = '0;
        for (int i = N_GO - 2; i >= 0; i--) begin
            if (req_rot[i]) begin
                skip_off = PH_W'(i);
            end
        end
        skip_go = srch_base + skip_off;
        if (skip_go >= PH_W'(N_GO)) begin
            skip_go = skip_go - PH_W'(N_GO);
        end
        skip_phase = {skip_go[PH_W-2:0], 1'b0};
    end
`endif

    // Next-phase and counter logic.
    always_comb begin
        dir      = phase_q[PH_W-1:2];
        k        = phase_q[1:0];
        legal    = (phase_q <= LAST_PH);
        go_sens  = (k == 2'd0) ? T[dir] : TL[dir];
        go_done  = (cnt_q >= MIN_LAST) &&
                   (!go_sens || ((MAX_GREEN != 0) && (cnt_q == MAX_LAST)));
        yel_done = (cnt_q == YEL_LAST);
        adv      = k[0] ? yel_done : go_done;
        seq_next = (phase_q == LAST_PH) ? '0 : phase_q + 1'b1;

        phase_d = phase_q;
        if (!legal) begin
            // Unused encodings (N_DIR not a power of two) fall back to phase 0.
            phase_d = '0;
        end else if (adv) begin
            phase_d = seq_next;
`ifdef TL_SKIP_EMPTY_EN
            if (k[0] && skip_hit) begin
                phase_d = skip_phase;
            end
`endif
        end

        phase_chg = !legal || adv;
        if (phase_chg) begin
            cnt_d = '0;
        end else if (cnt_q == CNT_SAT) begin
            cnt_d = cnt_q;
        end else begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    // Lamps are decoded from the next phase and registered, so they move on
    // the same edge as the phase and never see a sensor combinationally.
    always_comb begin
        l_d = '1;
        for (int d = 0; d < N_DIR; d++) begin
            if (phase_d[PH_W-1:2] == (PH_W-2)'(d)) begin
                case (phase_d[1:0])
                    2'd0:    l_d[2*d +: 2] = LAMP_GREEN;
                    2'd2:    l_d[2*d +: 2] = LAMP_LEFT;
                    default: l_d[2*d +: 2] = LAMP_YELLOW;
                endcase
            end else begin
                l_d[2*d +: 2] = LAMP_RED;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            phase_q <= '0;
            cnt_q   <= '0;
            l_q     <= RST_LAMP;
        end else begin
            phase_q <= phase_d;
            cnt_q   <= cnt_d;
            l_q     <= l_d;
        end
    end

    assign L     = l_q;
    assign phase = phase_q;

endmodule
